// File: rtl/event_encoder16_if.sv
// event_encoder16_if
//   Groups the request, code handshake and status signals of the 16-to-4 event
//   encoder.
//
//   Signals:
//     req          16  raw request lines (rising edge = event)
//     code          4  encoded index of the granted event
//     code_valid    1  code holds an event
//     code_ready    1  consumer accepts code this cycle
//     pending      16  buffered, not-yet-issued events
//     overrun       1  sticky overrun flag
//     clr_overrun   1  synchronous clear of overrun
//     busy          1  pending events or a code on offer
//
//   Modports:
//     slave  - the encoder: takes requests and ready, produces codes and status
//     master - the environment: drives requests and ready, observes codes
interface event_encoder16_if;
  logic [15:0] req;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] pending;
  logic        overrun;
  logic        clr_overrun;
  logic        busy;

  modport slave (
    input  req,
    input  code_ready,
    input  clr_overrun,
    output code,
    output code_valid,
    output pending,
    output overrun,
    output busy
  );

  modport master (
    output req,
    output code_ready,
    output clr_overrun,
    input  code,
    input  code_valid,
    input  pending,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/event_encoder16.sv
// event_encoder16
//   Sequential 16-to-4 encoder. Every rising edge on a request line becomes one
//   4-bit code on a valid/ready port. Edges are buffered in a sticky pending
//   register and arbitrated either by fixed priority (lowest index first) or
//   round-robin (search starts just after the last granted index).
//
//   Parameters:
//     ARB_MODE  0 = fixed priority, 1 = round-robin
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    event_encoder16_if.slave (req, code, code_valid, code_ready,
//            pending, overrun, clr_overrun, busy)
module event_encoder16 #(
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  event_encoder16_if.slave          bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Returns {found, index} of the winning pending bit. In round-robin mode the
  // scan starts at ptr+1 and wraps through 15 -> 0; the 4-bit add wraps for free.
  // Scanning from the far end down lets the nearest candidate overwrite the rest.
  function automatic logic [4:0] select_f(
    input logic [15:0] vec,
    input logic [3:0]  ptr,
    input logic        rr
  );
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      if (rr) begin
        idx = ptr + 4'd1 + 4'(k);
      end else begin
        idx = 4'(k);
      end
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  localparam logic RR_EN = (ARB_MODE != 0);

  state_t      state_q, state_d;
  logic [15:0] req_q;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  code_q, code_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        overrun_q, overrun_d;

  logic [15:0] rise_s;
  logic [4:0]  sel_s;
  logic        sel_found_s;
  logic [3:0]  sel_idx_s;
  logic        load_s;
  logic [15:0] load_mask_s;

  // Edge detection and arbitration over the registered pending set only.
  always_comb begin
    rise_s      = bus.req & ~req_q;
    sel_s       = select_f(pending_q, ptr_q, RR_EN);
    sel_found_s = sel_s[4];
    sel_idx_s   = sel_s[3:0];
  end

  // Handshake FSM: decides when a new code is loaded and the next state.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          load_s  = 1'b1;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // The current code's bit was already cleared when it was loaded, so any
        // remaining pending bit is a fresh candidate for back-to-back issue.
        if (bus.code_ready) begin
          if (sel_found_s) begin
            load_s  = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        load_s  = 1'b0;
      end
    endcase
  end

  // Pending, code, pointer and overrun next-state.
  always_comb begin
    if (load_s) begin
      load_mask_s = 16'd1 << sel_idx_s;
      code_d      = sel_idx_s;
      ptr_d       = sel_idx_s;
    end else begin
      load_mask_s = 16'd0;
      code_d      = code_q;
      ptr_d       = ptr_q;
    end
    // Set wins over the load clear: a rise on the bit being issued is a new event.
    pending_d = (pending_q & ~load_mask_s) | rise_s;
    // A new overrun in the same cycle as the clear takes precedence.
    if (|(rise_s & pending_q & ~load_mask_s)) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers. ptr resets to 15 so the first round-robin scan starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 16'd0;
      pending_q <= 16'd0;
      code_q    <= 4'd0;
      ptr_q     <= 4'd15;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Output mapping; code_valid is simply the SEND state.
  always_comb begin
    bus.code       = code_q;
    bus.code_valid = (state_q == ST_SEND);
    bus.pending    = pending_q;
    bus.overrun    = overrun_q;
    bus.busy       = (|pending_q) | (state_q == ST_SEND);
  end

endmodule

// File: tb/tb_event_encoder16.sv
// Directed testbench for event_encoder16: one fixed-priority and one round-robin
// instance share clock, reset and stimulus; expected values are hand-derived.
module tb_event_encoder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_s;
  logic        ready_s;
  logic        clr_s;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  event_encoder16_if if0 ();
  event_encoder16_if if1 ();

  assign if0.req         = req_s;
  assign if0.code_ready  = ready_s;
  assign if0.clr_overrun = clr_s;
  assign if1.req         = req_s;
  assign if1.code_ready  = ready_s;
  assign if1.clr_overrun = clr_s;

  event_encoder16 #(.ARB_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  event_encoder16 #(.ARB_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_s   = 16'd0;
    ready_s = 1'b0;
    clr_s   = 1'b0;
    #1;
    check("rst valid", 32'(if0.code_valid), 32'd0);
    check("rst code", 32'(if0.code), 32'd0);
    check("rst pending", 32'(if0.pending), 32'd0);
    check("rst overrun", 32'(if0.overrun), 32'd0);
    check("rst busy", 32'(if0.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single held-high request on line 5
    req_s   = 16'h0020;
    ready_s = 1'b1;
    step();
    check("t1 pending", 32'(if0.pending), 32'h0020);
    check("t1 valid0", 32'(if0.code_valid), 32'd0);
    step();
    check("t1 valid", 32'(if0.code_valid), 32'd1);
    check("t1 code", 32'(if0.code), 32'd5);
    check("t1 pend clr", 32'(if0.pending), 32'd0);
    step();
    check("t1 once", 32'(if0.code_valid), 32'd0);
    check("t1 busy", 32'(if0.busy), 32'd0);
    req_s = 16'd0;
    step();

    // 2: lines 0 and 15 together; rr instance has ptr=5 so 15 wins first there
    req_s = 16'h8001;
    step();
    req_s = 16'd0;
    check("t2 pending", 32'(if0.pending), 32'h8001);
    step();
    check("t2 code a", 32'(if0.code), 32'd0);
    check("t2 rr a", 32'(if1.code), 32'd15);
    check("t2 valid a", 32'(if0.code_valid), 32'd1);
    step();
    check("t2 code b", 32'(if0.code), 32'd15);
    check("t2 rr b", 32'(if1.code), 32'd0);
    check("t2 valid b", 32'(if0.code_valid), 32'd1);
    step();
    check("t2 idle", 32'(if0.code_valid), 32'd0);
    check("t2 hold code", 32'(if0.code), 32'd15);

    // 3: round-robin from reset (ptr=15)
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_s = 16'h000A;
    step();
    req_s = 16'd0;
    step();
    check("t3 rr 1", 32'(if1.code), 32'd1);
    step();
    check("t3 rr 3", 32'(if1.code), 32'd3);
    step();
    check("t3 idle", 32'(if1.code_valid), 32'd0);
    // ptr=3: scan 4..15 then 0..3 -> 0 before 2
    req_s = 16'h0005;
    step();
    req_s = 16'd0;
    step();
    check("t3 rr 0", 32'(if1.code), 32'd0);
    check("t3 fp 0", 32'(if0.code), 32'd0);
    step();
    check("t3 rr 2", 32'(if1.code), 32'd2);
    step();
    // move ptr to 1: scan 2..15 then 0 -> 2 before 0
    req_s = 16'h0002;
    step();
    req_s = 16'd0;
    step();
    check("t3 rr 1b", 32'(if1.code), 32'd1);
    step();
    req_s = 16'h0005;
    step();
    req_s = 16'd0;
    step();
    check("t3 rr 2b", 32'(if1.code), 32'd2);
    check("t3 fp 0b", 32'(if0.code), 32'd0);
    step();
    check("t3 rr 0b", 32'(if1.code), 32'd0);
    step();
    check("t3 idle b", 32'(if1.code_valid), 32'd0);

    // 4: stalled consumer, repeated pulses on line 2
    ready_s = 1'b0;
    req_s   = 16'h0004;
    step();
    req_s = 16'd0;
    step();
    check("t4 code", 32'(if0.code), 32'd2);
    check("t4 valid", 32'(if0.code_valid), 32'd1);
    req_s = 16'h0004;
    step();
    req_s = 16'd0;
    check("t4 pend", 32'(if0.pending), 32'h0004);
    check("t4 no ovr", 32'(if0.overrun), 32'd0);
    step();
    req_s = 16'h0004;
    step();
    req_s = 16'd0;
    check("t4 ovr", 32'(if0.overrun), 32'd1);
    check("t4 pend kept", 32'(if0.pending), 32'h0004);
    check("t4 code held", 32'(if0.code), 32'd2);
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    check("t4 clr", 32'(if0.overrun), 32'd0);
    check("t4 still valid", 32'(if0.code_valid), 32'd1);
    ready_s = 1'b1;
    step();
    check("t4 next code", 32'(if0.code), 32'd2);
    check("t4 next valid", 32'(if0.code_valid), 32'd1);
    check("t4 pend empty", 32'(if0.pending), 32'd0);
    step();
    check("t4 idle", 32'(if0.code_valid), 32'd0);

    // 5: all sixteen lines at once
    req_s = 16'hFFFF;
    step();
    req_s = 16'd0;
    check("t5 pending", 32'(if0.pending), 32'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("t5 code%0d", i), 32'(if0.code), 32'(i));
      check($sformatf("t5 valid%0d", i), 32'(if0.code_valid), 32'd1);
    end
    step();
    check("t5 idle", 32'(if0.code_valid), 32'd0);
    check("t5 busy", 32'(if0.busy), 32'd0);

    // 6: asynchronous reset in the middle of SEND
    ready_s = 1'b0;
    req_s   = 16'h0002;
    step();
    req_s = 16'd0;
    step();
    req_s = 16'h00F0;
    step();
    req_s = 16'd0;
    step();
    req_s = 16'h0010;
    step();
    req_s = 16'd0;
    step();
    check("t6 pending", 32'(if0.pending), 32'h00F0);
    check("t6 ovr", 32'(if0.overrun), 32'd1);
    check("t6 valid", 32'(if0.code_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    req_s = 16'h0010;
    #1;
    check("t6 rst valid", 32'(if0.code_valid), 32'd0);
    check("t6 rst pend", 32'(if0.pending), 32'd0);
    check("t6 rst ovr", 32'(if0.overrun), 32'd0);
    check("t6 rst busy", 32'(if0.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ready_s = 1'b1;
    step();
    check("t6 pend 4", 32'(if0.pending), 32'h0010);
    check("t6 wait", 32'(if0.code_valid), 32'd0);
    step();
    check("t6 code 4", 32'(if0.code), 32'd4);
    check("t6 valid 4", 32'(if0.code_valid), 32'd1);
    step();
    check("t6 idle", 32'(if0.code_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
